// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one bus request at a time and queues fetched
// words in a 2-entry buffer that the decode stage consumes, holds or flushes on redirect.
module fetch_ctrl #(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic [1:0]  cmd,
  input  logic [63:0] cmd_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        flush_if_id,
  output logic        iwait
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, STALL} state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
  } entry_t;

  localparam logic [1:0] CMD_SEQ = 2'b00;
  localparam logic [1:0] CMD_RED = 2'b10;

  state_e           state_q, state_d;
  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      req_addr_q, req_addr_d;
  entry_t [1:0]     fifo_q, fifo_d;
  logic [1:0]       count_q, count_d;

  logic             pop, redir, push;
  logic [1:0]       wr_idx;

  // Decode commands only mean something while a head instruction is presented.
  assign pop   = (count_q != 2'd0) && (cmd == CMD_SEQ);
  assign redir = (count_q != 2'd0) && (cmd == CMD_RED);
  assign push  = (state_q == FETCH) && iresp_data_ok && !redir;

  // Buffer update; a redirect empties it and wins over any same-cycle push.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    wr_idx  = count_q - {1'b0, pop};
    if (redir) begin
      count_d = 2'd0;
    end else begin
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) fifo_d[wr_idx[0]] = '{word: iresp_data, pc: req_addr_q};
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= PCINIT;
      req_addr_q <= PCINIT;
      fifo_q     <= '0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      fifo_q     <= fifo_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = fetch_pc_q;
      end
      FETCH: begin
        if (iresp_data_ok) begin
          if (redir) begin
            fetch_pc_d = cmd_target;
            req_addr_d = cmd_target;
          end else begin
            fetch_pc_d = req_addr_q + 64'd4;
            if (count_d == 2'd2) state_d = STALL;
            else                 req_addr_d = req_addr_q + 64'd4;
          end
        end else if (redir) begin
          // The in-flight request must still complete; its word is thrown away in DROP.
          state_d    = DROP;
          fetch_pc_d = cmd_target;
        end
      end
      DROP: begin
        if (iresp_data_ok) begin
          state_d    = FETCH;
          req_addr_d = fetch_pc_q;
        end
      end
      STALL: begin
        if (redir) begin
          state_d    = FETCH;
          fetch_pc_d = cmd_target;
          req_addr_d = cmd_target;
        end else if (pop) begin
          state_d    = FETCH;
          req_addr_d = fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ireq_valid  = (state_q == FETCH) || (state_q == DROP);
    ireq_addr   = req_addr_q;
    iwait       = ireq_valid && !iresp_data_ok;
    inst_valid  = (count_q != 2'd0);
    inst        = fifo_q[0].word;
    inst_pc     = fifo_q[0].pc;
    flush_if_id = redir;
  end

endmodule
